// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution unit.
// Holds the ARM condition-code encodings and the bit positions of the
// N, Z, C and V flags inside the architectural flag register.
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_eval.sv
// Purely combinational ARM condition evaluator.
// Ports:
//   cond     in  4  instruction condition field
//   nzcv     in  4  flags N,Z,C,V (bit 3 = N)
//   cond_raw out 1  1 when the instruction should execute
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       cond_raw
);

    logic n, z, c, v;

    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];

    always_comb begin
        cond_raw = 1'b1;
        case (cond)
            COND_EQ: cond_raw = z;
            COND_NE: cond_raw = ~z;
            COND_CS: cond_raw = c;
            COND_CC: cond_raw = ~c;
            COND_MI: cond_raw = n;
            COND_PL: cond_raw = ~n;
            COND_VS: cond_raw = v;
            COND_VC: cond_raw = ~v;
            COND_HI: cond_raw = c & ~z;
            COND_LS: cond_raw = ~c | z;
            COND_GE: cond_raw = (n == v);
            COND_LT: cond_raw = (n != v);
            COND_GT: cond_raw = ~z & (n == v);
            COND_LE: cond_raw = z | (n != v);
            // AL and the unconditional NV space both execute.
            default: cond_raw = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_exec_unit.sv
// Conditional-execution unit for the multicycle ARM controller.
// Evaluates the condition field, holds the execute decision for the whole
// instruction, applies grouped flag writes through a delay pipeline and
// keeps a flag save/restore stack for exception entry/return.
// Ports:
//   clk, reset                     clock, async active-high reset
//   Cond, ALUFlags, FlagW          condition field, ALU flags, group write requests
//   CondLatch                      decode strobe capturing the execute decision
//   PCS, NextPC, RegW, MemW        write requests from the decoder/FSM
//   FlagPush, FlagPop              flag stack save/restore
//   PCWrite, RegWrite, MemWrite    gated write enables
//   CondEx                         effective execute decision
//   Flags                          architectural flag register
//   StackEmpty, StackFull, StackErr stack status (StackErr sticky)
module cond_exec_unit
    import cond_pkg::*;
#(
    parameter int FLAGW       = 4,
    parameter int NGROUPS     = 2,
    parameter int FLAG_DELAY  = 1,
    parameter int STACK_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         Cond,
    input  logic [FLAGW-1:0]   ALUFlags,
    input  logic [NGROUPS-1:0] FlagW,
    input  logic               CondLatch,
    input  logic               PCS,
    input  logic               NextPC,
    input  logic               RegW,
    input  logic               MemW,
    input  logic               FlagPush,
    input  logic               FlagPop,
    output logic               PCWrite,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               CondEx,
    output logic [FLAGW-1:0]   Flags,
    output logic               StackEmpty,
    output logic               StackFull,
    output logic               StackErr
);

    localparam int GW = FLAGW / NGROUPS;
    localparam int PW = $clog2(STACK_DEPTH + 1);

    logic               cond_raw;
    logic               cond_ex_q, cond_ex_d, cond_ex_eff;
    logic [NGROUPS-1:0] flag_req, flag_write_dly;
    logic [FLAGW-1:0]   flags_q, flags_d;
    logic [FLAGW-1:0]   stack_q [STACK_DEPTH];
    logic [FLAGW-1:0]   stack_d [STACK_DEPTH];
    logic [FLAGW-1:0]   stack_top;
    logic [PW-1:0]      sp_q, sp_d;
    logic               err_q, err_d;
    logic               stack_empty, stack_full, push_ok, pop_ok, stack_bad;

    cond_eval u_cond_eval (
        .cond     (Cond),
        .nzcv     (flags_q[3:0]),
        .cond_raw (cond_raw)
    );

    // Reset forces the decision low so no write escapes while reset is held.
    always_comb begin
        cond_ex_d   = CondLatch ? cond_raw : cond_ex_q;
        cond_ex_eff = ~reset & cond_ex_d;
        flag_req    = FlagW & {NGROUPS{cond_ex_eff}};
    end

    generate
        if (FLAG_DELAY == 0) begin : g_no_delay
            assign flag_write_dly = flag_req;
        end else begin : g_delay
            logic [NGROUPS-1:0] pipe_q [FLAG_DELAY];
            logic [NGROUPS-1:0] pipe_d [FLAG_DELAY];

            always_comb begin
                pipe_d[0] = flag_req;
                for (int i = 1; i < FLAG_DELAY; i++) begin
                    pipe_d[i] = pipe_q[i-1];
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < FLAG_DELAY; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else begin
                    pipe_q <= pipe_d;
                end
            end

            assign flag_write_dly = pipe_q[FLAG_DELAY-1];
        end
    endgenerate

    // Stack pointer counts occupied entries; the top entry sits at sp_q-1.
    always_comb begin
        stack_empty = (sp_q == '0);
        stack_full  = (sp_q == PW'(STACK_DEPTH));
        push_ok     = FlagPush & ~FlagPop & ~stack_full;
        pop_ok      = FlagPop & ~FlagPush & ~stack_empty;
        stack_bad   = (FlagPush & FlagPop) | (FlagPush & stack_full) |
                      (FlagPop & stack_empty);

        stack_top = '0;
        stack_d   = stack_q;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp_q == PW'(i + 1)) stack_top = stack_q[i];
            if (push_ok && (sp_q == PW'(i))) stack_d[i] = flags_q;
        end

        sp_d = sp_q;
        if (push_ok)     sp_d = sp_q + 1'b1;
        else if (pop_ok) sp_d = sp_q - 1'b1;

        err_d = err_q | stack_bad;

        // Grouped writes first; a successful pop then overrides every group.
        flags_d = flags_q;
        for (int g = 0; g < NGROUPS; g++) begin
            if (flag_write_dly[g]) flags_d[g*GW +: GW] = ALUFlags[g*GW +: GW];
        end
        if (pop_ok) flags_d = stack_top;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cond_ex_q <= 1'b0;
            flags_q   <= '0;
            sp_q      <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            cond_ex_q <= cond_ex_d;
            flags_q   <= flags_d;
            sp_q      <= sp_d;
            err_q     <= err_d;
            stack_q   <= stack_d;
        end
    end

    assign CondEx     = cond_ex_eff;
    assign PCWrite    = (PCS & cond_ex_eff) | NextPC;
    assign RegWrite   = RegW & cond_ex_eff;
    assign MemWrite   = MemW & cond_ex_eff;
    assign Flags      = flags_q;
    assign StackEmpty = stack_empty;
    assign StackFull  = stack_full;
    assign StackErr   = err_q;

endmodule

// File: doc/cond_exec_unit.md
# cond_exec_unit

Parametrised conditional-execution unit for the multicycle ARM controller, and the successor to the fixed 4-flag condition logic.
- Evaluates the 4-bit condition field against the architectural flags.
- Latches the execute decision once per instruction so it holds across all of that instruction's states.
- Applies per-group flag writes through a configurable-delay enable pipeline.
- Provides a flag save/restore stack for exception entry and return.

It sits between the main FSM/decoder and the datapath, gating PCWrite, RegWrite and MemWrite.

## Interface
Parameters:
- FLAGW, 4: flag register width. Must be ≥ 4. Bits [3:0] are N,Z,C,V (bit 3 = N); upper bits are auxiliary flags.
- NGROUPS, 2: number of independently writable flag groups. FLAGW must be divisible by NGROUPS; group g covers bits [(g+1)·FLAGW/NGROUPS-1 : g·FLAGW/NGROUPS].
- FLAG_DELAY, 1: cycles between the flag-write request and the flag register update. Legal range 0–3.
- STACK_DEPTH, 4: entries in the flag save stack. Must be ≥ 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- Cond  in  4  instruction condition field
- ALUFlags  in  FLAGW  flags produced by the ALU
- FlagW  in  NGROUPS  per-group flag-write request
- CondLatch  in  1  decode strobe: evaluate and capture the execute decision
- PCS  in  1  instruction writes the PC
- NextPC  in  1  FSM PC increment
- RegW  in  1  register-write request
- MemW  in  1  memory-write request
- FlagPush  in  1  save Flags onto the stack
- FlagPop  in  1  restore Flags from the stack
- PCWrite  out  1  (PCS & CondExEff) | NextPC
- RegWrite  out  1  RegW & CondExEff
- MemWrite  out  1  MemW & CondExEff
- CondEx  out  1  current effective execute decision (CondExEff)
- Flags  out  FLAGW  architectural flag register
- StackEmpty  out  1  stack holds 0 entries
- StackFull  out  1  stack holds STACK_DEPTH entries
- StackErr  out  1  sticky error flag

## Operation
- **Condition evaluation:** CondRaw = cond_eval(Cond, Flags[3:0]) with standard ARM semantics, EQ through AL. Code 4'b1111 evaluates true.
- **Effective decision:** CondExEff = CondLatch ? CondRaw : CondExQ.
  - CondExQ loads CondRaw on every edge where CondLatch = 1 and otherwise holds.
  - The decision therefore stays fixed for the whole instruction, even if Flags change mid-instruction.
- **Flag-write pipeline:** the request FlagW & {NGROUPS{CondExEff}} passes through FLAG_DELAY register stages, giving FlagWriteD.
  - With FLAG_DELAY = 0, FlagWriteD is the request itself (combinational).
  - On each edge, every group g with FlagWriteD[g] = 1 loads its slice from the ALUFlags value present in that cycle.
- **Push:** stores the pre-edge Flags value at the stack pointer and increments the pointer.
- **Pop:** decrements the pointer and loads Flags with the top entry. For every group, a pop overrides a FlagWriteD write in the same cycle.
- **Boundary conditions:**
  - Push while StackFull: stack unchanged, StackErr := 1.
  - Pop while StackEmpty: Flags follow FlagWriteD only, StackErr := 1.
  - Push and pop in the same cycle: neither takes effect, StackErr := 1.
- **StackErr:** sticky; cleared only by reset.
- **Reset:** asynchronous, at any time.
  - Flags = 0 and CondExQ = 0.
  - All pipeline stages = 0, so in-flight flag writes are discarded.
  - Stack pointer = 0, giving StackEmpty = 1 and StackFull = 0.
  - StackErr = 0.
  - PCWrite = NextPC, RegWrite = 0, MemWrite = 0.

## Timing
- CondEx, PCWrite, RegWrite and MemWrite are combinational from CondLatch, Cond, Flags and the request inputs, all in the same cycle.
- A flag write requested in cycle t updates Flags at the edge ending cycle t + FLAG_DELAY and becomes visible in cycle t + FLAG_DELAY + 1.
- Push and pop take effect at the edge ending the cycle in which they are asserted. Popped flags are visible in the next cycle.
- StackEmpty and StackFull are registered-state decodes; they are valid in the cycle after the push or pop.

## Structure
- Shared package cond_pkg holds:
  - cond-code localparams COND_EQ through COND_AL and COND_NV;
  - flag indices FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0.
- One sub-module, cond_eval: purely combinational (Cond, NZCV) → CondRaw.
- The top level contains CondExQ, the delay pipeline, per-group flag enables and the stack (register array plus a $clog2(STACK_DEPTH+1)-bit pointer).

## Test plan
All scenarios use default parameters unless stated.

1. **Reset:** assert reset mid-cycle with a pending write → Flags = 0, StackEmpty = 1 immediately. After release, the pending write never lands.
2. **Latched decision:** Flags = 4'b0100 (Z), Cond = EQ, CondLatch pulse → CondEx = 1. Then Flags change to 0 and RegW = 1 is held 3 cycles without CondLatch → RegWrite = 1 in all 3 cycles.
3. **Delayed, grouped write:**
   - FlagW = 2'b10, ALUFlags = 4'b1111 at t → Flags = 4'b1100 at t+2.
   - Cond = NE with Z set, FlagW = 2'b11 → Flags unchanged.
4. **Stack round-trip:**
   - Push Flags = 4'b1010, write Flags to 4'b0101, pop → Flags = 4'b1010, StackEmpty = 1.
   - Five pushes at depth 4 → StackFull = 1, StackErr = 1.
5. **Collisions:**
   - Pop in the same cycle as a group-1 write → popped value wins.
   - Push and pop together → pointer unchanged, StackErr = 1.
   - Pop when empty → StackErr = 1.
6. **Parameter sweep:**
   - FLAGW = 8, NGROUPS = 4, FLAG_DELAY = 0: FlagW = 4'b0100, ALUFlags = 8'hA5 → Flags[5:4] = 2'b10 at the next edge, other bits held.
   - Cond = 4'b1111 → CondEx = 1.
   - With PCS = 0 and NextPC = 1: PCWrite = 1.
